// File: rtl/alu_op_sequencer_if.sv
// Command/response bundle between a command source and alu_op_sequencer.
// master: command source / response consumer. slave: the sequencer.
//   cmd_*  : valid/ready command channel (op, operands, flag-in)
//   rsp_*  : valid/ready response channel (result, zero, carry, illegal)
interface alu_op_sequencer_if #(
    parameter int unsigned BITS = 4
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [3:0]      cmd_op;
    logic [BITS-1:0] cmd_a;
    logic [BITS-1:0] cmd_b;
    logic            cmd_flag;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [BITS-1:0] rsp_result;
    logic            rsp_zero;
    logic            rsp_carry;
    logic            rsp_illegal;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_flag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_illegal
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_flag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_illegal
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Initiator-side controller for a combinational ALU: accepts one command,
// holds it registered on the ALU inputs for SETTLE cycles, captures the
// result/flags and returns them on the response channel.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   bus (slave)   : cmd_* command channel in, rsp_* response channel out
//   alu_a/alu_b/alu_control/alu_flag_in : registered ALU inputs
//   alu_result/alu_flags/alu_cflag      : ALU outputs (bit 0 of flags/cflag used)
//   busy          : state is not IDLE
//   ops_done      : wrapping count of completed response handshakes
module alu_op_sequencer #(
    parameter int unsigned BITS   = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    alu_op_sequencer_if.slave bus,
    output logic [BITS-1:0]   alu_a,
    output logic [BITS-1:0]   alu_b,
    output logic [3:0]        alu_control,
    output logic              alu_flag_in,
    input  logic [BITS-1:0]   alu_result,
    input  logic [1:0]        alu_flags,
    input  logic [1:0]        alu_cflag,
    output logic              busy,
    output logic [15:0]       ops_done
);
    localparam int unsigned OP_W  = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned OPS_W = 16;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;

    localparam logic [OP_W-1:0] OP_SHL      = 4'b1000;
    localparam logic [OP_W-1:0] OP_SHR      = 4'b1001;
    localparam logic [OP_W-1:0] OP_FIRST_NA = 4'b1010;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             illegal_q;

    logic             accept_c;
    logic             capture_c;
    logic             done_c;
    logic             cmd_shift_c;
    logic             cmd_illegal_c;
    logic             alu_shift_c;
    logic             unused_flag_bits;

    // Only bit 0 of the ALU flag vectors carries information here.
    assign unused_flag_bits = alu_flags[1] ^ alu_cflag[1];

    // Illegal: unassigned opcodes, or a shift amount that does not fit the width.
    assign cmd_shift_c   = (bus.cmd_op == OP_SHL) || (bus.cmd_op == OP_SHR);
    assign cmd_illegal_c = (bus.cmd_op >= OP_FIRST_NA) ||
                           (cmd_shift_c && (32'(bus.cmd_b) >= BITS));
    assign alu_shift_c   = (alu_control == OP_SHL) || (alu_control == OP_SHR);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake strobes
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        done_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    accept_c  = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cnt == '0) begin
                    capture_c = 1'b1;
                    state_nxt = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (bus.rsp_ready) begin
                    done_c    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered status outputs, decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            bus.cmd_ready <= (state_nxt == S_IDLE);
            bus.rsp_valid <= (state_nxt == S_RESPOND);
            busy          <= (state_nxt != S_IDLE);
        end
    end

    // Settle counter and illegal latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            illegal_q <= 1'b0;
        end else if (accept_c) begin
            cnt       <= CNT_W'(SETTLE - 1);
            illegal_q <= cmd_illegal_c;
        end else if ((state == S_ISSUE) && (cnt != '0)) begin
            cnt       <= cnt - CNT_W'(1);
        end
    end

    // ALU input registers, frozen until the next accepted command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            alu_flag_in <= 1'b0;
        end else if (accept_c) begin
            alu_a       <= bus.cmd_a;
            alu_b       <= bus.cmd_b;
            alu_control <= bus.cmd_op;
            alu_flag_in <= bus.cmd_flag;
        end
    end

    // Response capture; carry is meaningful only for a legal shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_result  <= '0;
            bus.rsp_zero    <= 1'b0;
            bus.rsp_carry   <= 1'b0;
            bus.rsp_illegal <= 1'b0;
        end else if (capture_c) begin
            bus.rsp_result  <= alu_result;
            bus.rsp_zero    <= alu_flags[0];
            bus.rsp_carry   <= alu_shift_c && !illegal_q && alu_cflag[0];
            bus.rsp_illegal <= illegal_q;
        end
    end

    // Completed-operation counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_done <= '0;
        end else if (done_c) begin
            ops_done <= ops_done + OPS_W'(1);
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: SETTLE=1 and SETTLE=3 instances, each driving
// a behavioural ALU, checked every cycle against a transaction-level model.
module tb_alu_op_sequencer;
    localparam int unsigned BITS = 4;

    logic clk  = 1'b0;
    logic rst1 = 1'b1;
    logic rst3 = 1'b1;
    logic pre3 = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    alu_op_sequencer_if #(.BITS(BITS)) if1 ();
    alu_op_sequencer_if #(.BITS(BITS)) if3 ();

    logic [BITS-1:0] a1, b1, r1, a3, b3, r3;
    logic [3:0]      ctl1, ctl3;
    logic            fi1, fi3, busy1, busy3;
    logic [1:0]      fl1, cf1, fl3, cf3;
    logic [15:0]     ops1, ops3;
    logic [BITS+1:0] alu1_c, alu3_c;

    alu_op_sequencer #(.BITS(BITS), .SETTLE(1)) u1 (
        .clk(clk), .rst(rst1), .bus(if1),
        .alu_a(a1), .alu_b(b1), .alu_control(ctl1), .alu_flag_in(fi1),
        .alu_result(r1), .alu_flags(fl1), .alu_cflag(cf1),
        .busy(busy1), .ops_done(ops1)
    );

    alu_op_sequencer #(.BITS(BITS), .SETTLE(3)) u3 (
        .clk(clk), .rst(rst3), .bus(if3),
        .alu_a(a3), .alu_b(b3), .alu_control(ctl3), .alu_flag_in(fi3),
        .alu_result(r3), .alu_flags(fl3), .alu_cflag(cf3),
        .busy(busy3), .ops_done(ops3)
    );

    // Behavioural ALU: returns {carry, zero, result}
    function automatic logic [BITS+1:0] alu_ref(input logic [3:0] op, input logic [BITS-1:0] a,
                                                input logic [BITS-1:0] b, input logic f);
        logic [BITS-1:0]   r;
        logic              c;
        logic [2*BITS-1:0] w;
        c = 1'b0;
        w = '0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a ^ b;
            4'b0011: r = ~a;
            4'b0100: r = a + b;
            4'b0101: r = a + b + BITS'(f);
            4'b0110: r = a - b;
            4'b0111: r = b - a;
            4'b1000: begin w = {{BITS{1'b0}}, a} << b; r = w[BITS-1:0];      c = w[BITS];   end
            4'b1001: begin w = {a, {BITS{1'b0}}} >> b; r = w[2*BITS-1:BITS]; c = w[BITS-1]; end
            default: r = a + b + BITS'(f);
        endcase
        return {c, (r == '0), r};
    endfunction

    assign alu1_c = alu_ref(ctl1, a1, b1, fi1);
    assign r1  = alu1_c[BITS-1:0];
    assign fl1 = {1'b0, alu1_c[BITS]};
    assign cf1 = {1'b0, alu1_c[BITS+1]};
    assign alu3_c = alu_ref(ctl3, a3, b3, fi3);
    assign r3  = alu3_c[BITS-1:0];
    assign fl3 = {1'b0, alu3_c[BITS]};
    assign cf3 = {1'b0, alu3_c[BITS+1]};

    // Transaction-level model of one sequencer
    typedef struct {
        bit              idle;
        bit              pend;
        int              wait_n;
        logic [3:0]      op;
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        logic            f;
        logic [BITS-1:0] res;
        logic            zero;
        logic            carry;
        logic            ill;
        logic [15:0]     ops;
    } mdl_t;

    mdl_t m1, m3;

    function automatic mdl_t mdl_reset();
        mdl_t s;
        s.idle = 1'b1; s.pend = 1'b0; s.wait_n = 0;
        s.op = '0; s.a = '0; s.b = '0; s.f = 1'b0;
        s.res = '0; s.zero = 1'b0; s.carry = 1'b0; s.ill = 1'b0; s.ops = '0;
        return s;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t s, input int settle, input logic cv,
                                      input logic [3:0] op, input logic [BITS-1:0] a,
                                      input logic [BITS-1:0] b, input logic f,
                                      input logic rr, input logic pre);
        mdl_t n;
        logic [BITS+1:0] alu;
        logic shift;
        n = s;
        if (s.pend) begin
            if (rr) begin
                n.pend = 1'b0;
                n.idle = 1'b1;
                n.ops  = s.ops + 16'd1;
            end
        end else if (!s.idle) begin
            n.wait_n = s.wait_n - 1;
            if (n.wait_n == 0) n.pend = 1'b1;
        end else if (cv) begin
            alu     = alu_ref(op, a, b, f);
            shift   = (op == 4'b1000) || (op == 4'b1001);
            n.idle  = 1'b0;
            n.wait_n = settle;
            n.op = op; n.a = a; n.b = b; n.f = f;
            n.ill   = (op >= 4'b1010) || (shift && (32'(b) >= BITS));
            n.res   = alu[BITS-1:0];
            n.zero  = alu[BITS];
            n.carry = shift && !n.ill && alu[BITS+1];
        end
        if (pre) n.ops = 16'hFFFE;
        return n;
    endfunction

    always @(posedge clk or posedge rst1) begin
        if (rst1) m1 <= mdl_reset();
        else      m1 <= mdl_step(m1, 1, if1.cmd_valid, if1.cmd_op, if1.cmd_a, if1.cmd_b,
                                 if1.cmd_flag, if1.rsp_ready, 1'b0);
    end

    always @(posedge clk or posedge rst3) begin
        if (rst3) m3 <= mdl_reset();
        else      m3 <= mdl_step(m3, 3, if3.cmd_valid, if3.cmd_op, if3.cmd_a, if3.cmd_b,
                                 if3.cmd_flag, if3.rsp_ready, pre3);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string t, input mdl_t s, input logic rdy, input logic vld,
                       input logic bsy, input logic [15:0] ops, input logic [3:0] ctl,
                       input logic [BITS-1:0] aa, input logic [BITS-1:0] bb, input logic fi,
                       input logic [BITS-1:0] res, input logic z, input logic c, input logic il);
        chk({t, ".cmd_ready"}, 32'(rdy), 32'(s.idle));
        chk({t, ".rsp_valid"}, 32'(vld), 32'(s.pend));
        chk({t, ".busy"},      32'(bsy), 32'(!s.idle));
        chk({t, ".ops_done"},  32'(ops), 32'(s.ops));
        if (!s.idle) begin
            chk({t, ".alu_control"}, 32'(ctl), 32'(s.op));
            chk({t, ".alu_a"},       32'(aa),  32'(s.a));
            chk({t, ".alu_b"},       32'(bb),  32'(s.b));
            chk({t, ".alu_flag_in"}, 32'(fi),  32'(s.f));
        end
        if (s.pend) begin
            chk({t, ".rsp_result"},  32'(res), 32'(s.res));
            chk({t, ".rsp_zero"},    32'(z),   32'(s.zero));
            chk({t, ".rsp_carry"},   32'(c),   32'(s.carry));
            chk({t, ".rsp_illegal"}, 32'(il),  32'(s.ill));
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        cmp("u1", m1, if1.cmd_ready, if1.rsp_valid, busy1, ops1, ctl1, a1, b1, fi1,
            if1.rsp_result, if1.rsp_zero, if1.rsp_carry, if1.rsp_illegal);
        cmp("u3", m3, if3.cmd_ready, if3.rsp_valid, busy3, ops3, ctl3, a3, b3, fi3,
            if3.rsp_result, if3.rsp_zero, if3.rsp_carry, if3.rsp_illegal);
    end

    // One directed transaction on u1 with literal expectations; entered just after a negedge
    task automatic txn1(input string t, input logic [3:0] op, input logic [BITS-1:0] a,
                        input logic [BITS-1:0] b, input logic f, input int hold,
                        input logic [BITS-1:0] e_res, input logic e_z, input logic e_c,
                        input logic e_il, input logic [15:0] e_ops);
        int n;
        if1.cmd_valid = 1'b1; if1.cmd_op = op; if1.cmd_a = a; if1.cmd_b = b; if1.cmd_flag = f;
        if1.rsp_ready = 1'b0;
        n = 0;
        while (!if1.cmd_ready && n < 20) begin @(negedge clk); n++; end
        chk({t, ".accept"}, 32'(if1.cmd_ready), 32'd1);
        @(negedge clk);
        if1.cmd_valid = 1'b0;
        if1.cmd_op = 4'($urandom); if1.cmd_a = BITS'($urandom); if1.cmd_b = BITS'($urandom);
        if1.cmd_flag = 1'($urandom);
        n = 0;
        while (!if1.rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk({t, ".latency"},  32'(n), 32'd1);
        chk({t, ".result"},   32'(if1.rsp_result),  32'(e_res));
        chk({t, ".zero"},     32'(if1.rsp_zero),    32'(e_z));
        chk({t, ".carry"},    32'(if1.rsp_carry),   32'(e_c));
        chk({t, ".illegal"},  32'(if1.rsp_illegal), 32'(e_il));
        repeat (hold) begin
            @(negedge clk);
            chk({t, ".hold_valid"},   32'(if1.rsp_valid),   32'd1);
            chk({t, ".hold_result"},  32'(if1.rsp_result),  32'(e_res));
            chk({t, ".hold_illegal"}, 32'(if1.rsp_illegal), 32'(e_il));
            chk({t, ".hold_ready"},   32'(if1.cmd_ready),   32'd0);
            chk({t, ".hold_busy"},    32'(busy1),           32'd1);
        end
        if1.rsp_ready = 1'b1;
        @(negedge clk);
        if1.rsp_ready = 1'b0;
        chk({t, ".ops_done"}, 32'(ops1), 32'(e_ops));
        chk({t, ".back_idle"}, 32'(if1.cmd_ready), 32'd1);
    endtask

    task automatic rst_checks1(input string t);
        chk({t, ".cmd_ready"},   32'(if1.cmd_ready),   32'd1);
        chk({t, ".rsp_valid"},   32'(if1.rsp_valid),   32'd0);
        chk({t, ".busy"},        32'(busy1),           32'd0);
        chk({t, ".alu_a"},       32'(a1),              32'd0);
        chk({t, ".alu_control"}, 32'(ctl1),            32'd0);
        chk({t, ".rsp_result"},  32'(if1.rsp_result),  32'd0);
        chk({t, ".ops_done"},    32'(ops1),            32'd0);
    endtask

    task automatic drv1();
        repeat (2) @(negedge clk);
        rst_checks1("u1.reset");
        #2 rst1 = 1'b0;
        @(negedge clk);

        txn1("and",     4'b0000, 4'hC, 4'hA, 1'b0, 0, 4'h8, 1'b0, 1'b0, 1'b0, 16'd1);
        txn1("sub0",    4'b0110, 4'h5, 4'h5, 1'b0, 0, 4'h0, 1'b1, 1'b0, 1'b0, 16'd2);
        txn1("shl",     4'b1000, 4'h6, 4'h2, 1'b0, 0, 4'h8, 1'b0, 1'b1, 1'b0, 16'd3);
        txn1("shl_b5",  4'b1000, 4'h6, 4'h5, 1'b0, 0, 4'h0, 1'b1, 1'b0, 1'b1, 16'd4);
        txn1("shl_b4",  4'b1000, 4'h9, 4'h4, 1'b0, 0, 4'h0, 1'b1, 1'b0, 1'b1, 16'd5);
        txn1("op1011",  4'b1011, 4'h3, 4'h4, 1'b1, 5, 4'h8, 1'b0, 1'b0, 1'b1, 16'd6);
        txn1("shr",     4'b1001, 4'h9, 4'h1, 1'b0, 0, 4'h4, 1'b0, 1'b1, 1'b0, 16'd7);

        // Command waiting while the response completes is taken only in the next IDLE cycle
        if1.cmd_valid = 1'b1; if1.cmd_op = 4'b0000; if1.cmd_a = 4'hF; if1.cmd_b = 4'hF;
        if1.cmd_flag = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("simul.rsp_valid", 32'(if1.rsp_valid), 32'd1);
        if1.rsp_ready = 1'b1;
        @(negedge clk);
        if1.rsp_ready = 1'b0;
        chk("simul.not_taken", 32'(busy1), 32'd0);
        chk("simul.ops_done", 32'(ops1), 32'd8);
        @(negedge clk);
        if1.cmd_valid = 1'b0;
        chk("simul.taken_next", 32'(busy1), 32'd1);
        @(negedge clk);
        chk("simul.result", 32'(if1.rsp_result), 32'hF);
        if1.rsp_ready = 1'b1;
        @(negedge clk);
        if1.rsp_ready = 1'b0;
        chk("simul.ops_done2", 32'(ops1), 32'd9);

        // Reset while in ISSUE
        if1.cmd_valid = 1'b1; if1.cmd_op = 4'b0100; if1.cmd_a = 4'h3; if1.cmd_b = 4'h4;
        @(negedge clk);
        if1.cmd_valid = 1'b0;
        chk("rst_issue.busy_before", 32'(busy1), 32'd1);
        #2 rst1 = 1'b1;
        #1 rst_checks1("rst_issue");
        @(negedge clk);
        #2 rst1 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_issue.no_rsp", 32'(if1.rsp_valid), 32'd0);
        end

        // Reset while in RESPOND
        if1.cmd_valid = 1'b1; if1.cmd_op = 4'b0001; if1.cmd_a = 4'h5; if1.cmd_b = 4'h2;
        @(negedge clk);
        if1.cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_respond.valid_before", 32'(if1.rsp_valid), 32'd1);
        chk("rst_respond.result_before", 32'(if1.rsp_result), 32'h7);
        #2 rst1 = 1'b1;
        #1 rst_checks1("rst_respond");
        @(negedge clk);
        #2 rst1 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_respond.no_rsp", 32'(if1.rsp_valid), 32'd0);
        end

        // Randomized traffic, including cmd_valid toggling outside the handshake
        repeat (400) begin
            @(negedge clk);
            if1.cmd_valid = 1'($urandom);
            if1.cmd_op    = 4'($urandom);
            if1.cmd_a     = BITS'($urandom);
            if1.cmd_b     = BITS'($urandom);
            if1.cmd_flag  = 1'($urandom);
            if1.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        if1.cmd_valid = 1'b0;
    endtask

    task automatic drv3();
        int last;
        int cyc;
        int acc;
        int n;
        repeat (2) @(negedge clk);
        #2 rst3 = 1'b0;
        if3.cmd_valid = 1'b1;
        if3.rsp_ready = 1'b1;
        last = 0; cyc = 0; acc = 0;
        @(negedge clk);
        // Back-to-back: acceptance edges must be SETTLE+2 = 5 cycles apart
        while (acc < 6 && cyc < 60) begin
            if3.cmd_op = 4'($urandom); if3.cmd_a = BITS'($urandom);
            if3.cmd_b = BITS'($urandom); if3.cmd_flag = 1'($urandom);
            if (if3.cmd_ready) begin
                if (acc > 0) chk("u3.accept_spacing", 32'(cyc - last), 32'd5);
                last = cyc;
                acc++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("u3.accept_count", 32'(acc), 32'd6);
        if3.cmd_valid = 1'b0;
        n = 0;
        while (!if3.cmd_ready && n < 20) begin @(negedge clk); n++; end
        chk("u3.drain", 32'(if3.cmd_ready), 32'd1);

        // Preload the completion counter near its wrap point
        @(negedge clk);
        #2;
        force u3.ops_done = 16'hFFFE;
        pre3 = 1'b1;
        @(posedge clk);
        #1;
        release u3.ops_done;
        pre3 = 1'b0;
        @(negedge clk);
        if3.cmd_valid = 1'b1;
        acc = 0; cyc = 0;
        while (acc < 2 && cyc < 30) begin
            if (if3.cmd_ready) acc++;
            @(negedge clk);
            cyc++;
        end
        if3.cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("u3.ops_wrap", 32'(ops3), 32'h0000);

        repeat (400) begin
            @(negedge clk);
            if3.cmd_valid = 1'($urandom);
            if3.cmd_op    = 4'($urandom);
            if3.cmd_a     = BITS'($urandom);
            if3.cmd_b     = BITS'($urandom);
            if3.cmd_flag  = 1'($urandom);
            if3.rsp_ready = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        if3.cmd_valid = 1'b0;
    endtask

    initial begin
        if1.cmd_valid = 1'b0; if1.cmd_op = '0; if1.cmd_a = '0; if1.cmd_b = '0;
        if1.cmd_flag = 1'b0; if1.rsp_ready = 1'b0;
        if3.cmd_valid = 1'b0; if3.cmd_op = '0; if3.cmd_a = '0; if3.cmd_b = '0;
        if3.cmd_flag = 1'b0; if3.rsp_ready = 1'b0;
        fork
            drv1();
            drv3();
        join
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete by %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
